// File: rtl/eaglesong_sponge_ctrl.sv
// eaglesong_sponge_ctrl: Eaglesong sponge absorb/pad/squeeze controller driving an external permutation core
module eaglesong_sponge_ctrl #(
  parameter logic [7:0] DELIM = 8'h06
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       msg_data,
  input  logic              msg_valid,
  input  logic              msg_last,
  input  logic [1:0]        msg_last_bytes,
  output logic              msg_ready,
  output logic [15:0][31:0] perm_state_out,
  output logic              perm_start,
  input  logic [15:0][31:0] perm_state_in,
  input  logic              perm_done,
  output logic [7:0][31:0]  digest,
  output logic              digest_valid,
  input  logic              digest_ack
);
  typedef enum logic [1:0] {ABSORB, START, WAIT, OUTPUT} fsm_t;
  fsm_t fsm, fsm_n;
  logic [15:0][31:0] st, st_n;
  logic [7:0][31:0] dig_n;
  logic [2:0] k, k_n;
  logic fin, fin_n, pad, pad_n, first, first_n, alive, full;
  logic [31:0] w;
  assign full = msg_last_bytes == 2'd0;
  assign w = !msg_last || full ? msg_data :
             msg_last_bytes == 2'd1 ? {msg_data[31:24], DELIM, 16'h0} :
             msg_last_bytes == 2'd2 ? {msg_data[31:16], DELIM, 8'h0} : {msg_data[31:8], DELIM};
  assign msg_ready = alive && fsm == ABSORB;
  assign perm_start = fsm == START;
  assign digest_valid = fsm == OUTPUT;
  assign perm_state_out = st;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fsm <= ABSORB;
      st <= '0;
      digest <= '0;
      k <= 3'd0;
      fin <= 1'b0;
      pad <= 1'b0;
      first <= 1'b0;
      alive <= 1'b0;
    end else begin
      fsm <= fsm_n;
      st <= st_n;
      digest <= dig_n;
      k <= k_n;
      fin <= fin_n;
      pad <= pad_n;
      first <= first_n;
      alive <= 1'b1;
    end
  always_comb begin
    fsm_n = fsm;
    st_n = st;
    dig_n = digest;
    k_n = k;
    fin_n = fin;
    pad_n = pad;
    first_n = 1'b0;
    if (fsm == ABSORB && msg_valid && msg_ready) begin
      st_n[k] = st[k] ^ w;
      k_n = msg_last ? 3'd0 : k + 3'd1;
      if (msg_last && full && k != 3'd7) st_n[k + 3'd1] = st[k + 3'd1] ^ {DELIM, 24'h0};
      if (msg_last) {fin_n, pad_n} = full && k == 3'd7 ? 2'b01 : 2'b10;
      if (msg_last || k == 3'd7) fsm_n = START;
    end
    if (fsm == START) begin
      fsm_n = WAIT;
      first_n = 1'b1;
    end
    if (fsm == WAIT && !first && perm_done) begin
      fsm_n = fin ? OUTPUT : pad ? START : ABSORB;
      if (fin) dig_n = perm_state_in[7:0];
      else begin
        st_n = perm_state_in;
        if (pad) st_n[0] = perm_state_in[0] ^ {DELIM, 24'h0};
      end
      fin_n = fin | pad;
      pad_n = 1'b0;
    end
    if (fsm == OUTPUT && digest_ack) begin
      fsm_n = ABSORB;
      st_n = '0;
      k_n = 3'd0;
      fin_n = 1'b0;
      pad_n = 1'b0;
    end
  end
endmodule
